// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle shared between the eight requesters and the arbiter.
// The master side drives the request lines and receives the grant.
// The slave side is the arbiter itself.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a programmable hold limit.
// The grant is presented both as an index and as a one-hot vector.
// Every grant is followed by at least one idle cycle.
// HOLD_MAX = 0 disables the forced release.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  localparam int HC_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);
  localparam logic [HC_W-1:0] HC_SAT   = {HC_W{1'b1}};

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      idx_q, idx_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]      grant_q, grant_d;
  logic            timeout_q, timeout_d;

  logic [7:0]      req;
  logic            pick_found;
  logic [2:0]      pick_idx;
  logic [2:0]      cand;

  assign req = bus.req;

  // Rotating search: first set request starting at ptr, wrapping 7 -> 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          idx_d      = pick_idx;
          hold_cnt_d = HC_W'(1);
          grant_d    = 8'b1 << pick_idx;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          // Winner let go; a coincident hold expiry counts as a normal release.
          state_d = ST_IDLE;
          ptr_d   = idx_q + 3'd1;
          grant_d = 8'h00;
        end else if ((HOLD_MAX != 0) && (hold_cnt_q == HOLD_LIM)) begin
          // Winner kept requesting past the limit: take the grant away.
          state_d   = ST_IDLE;
          ptr_d     = idx_q + 3'd1;
          grant_d   = 8'h00;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != HC_SAT) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 3'd0;
      idx_q      <= 3'd0;
      hold_cnt_q <= '0;
      grant_q    <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = (state_q == ST_GRANT);
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (HOLD_MAX = 4).
// Stimulus pushes the expected post-edge outputs tagged with a cycle number.
// A monitor pops and compares them on the falling edge of that cycle.
module tb_rr_arbiter8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter8_if arb_if ();

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive req for the next edge and queue the outputs expected after it.
  task automatic drive(input string tag, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] i, input logic v, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    arb_if.req = r;
    e.cyc   = cyc + 1;
    e.tag   = tag;
    e.grant = g;
    e.idx   = i;
    e.valid = v;
    e.to    = t;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc != cyc) check({e.tag, ".late"}, cyc, e.cyc);
        check({e.tag, ".grant"},       arb_if.grant,       e.grant);
        check({e.tag, ".grant_idx"},   arb_if.grant_idx,   e.idx);
        check({e.tag, ".grant_valid"}, arb_if.grant_valid, e.valid);
        check({e.tag, ".timeout"},     arb_if.timeout,     e.to);
      end
    end
  end

  initial begin
    logic [7:0] b;
    rst_n      = 1'b0;
    arb_if.req = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst.grant",       arb_if.grant,       8'h00);
    check("rst.grant_idx",   arb_if.grant_idx,   3'd0);
    check("rst.grant_valid", arb_if.grant_valid, 1'b0);
    check("rst.timeout",     arb_if.timeout,     1'b0);
    arb_if.req = 8'h00;
    rst_n      = 1'b1;

    drive("idle", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // Full rotation from ptr = 0: each winner holds two cycles, then drops for one.
    for (int k = 0; k < 9; k++) begin
      b = 8'b1 << (k % 8);
      drive("rot", 8'hFF, b, 3'(k % 8), 1'b1, 1'b0);
      drive("rot", 8'hFF, b, 3'(k % 8), 1'b1, 1'b0);
      drive("rot", 8'hFF & ~b, 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end
    // ptr = 1 now.

    // Single requester 3 for three cycles.
    drive("single", 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    drive("single", 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    drive("single", 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    drive("single", 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    // ptr = 4.

    // No preemption: 1 and 3 arrive while 2 holds; release wins over new arrivals.
    drive("nopre", 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    drive("nopre", 8'h0E, 8'h04, 3'd2, 1'b1, 1'b0);
    drive("nopre", 8'h0E, 8'h04, 3'd2, 1'b1, 1'b0);
    drive("nopre", 8'h0A, 8'h00, 3'd2, 1'b0, 1'b0);
    drive("nopre", 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0);
    drive("nopre", 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    // ptr = 4.

    // Forced release after four cycles, then the other pending requester wins.
    drive("tmo", 8'h60, 8'h20, 3'd5, 1'b1, 1'b0);
    drive("tmo", 8'h60, 8'h20, 3'd5, 1'b1, 1'b0);
    drive("tmo", 8'h60, 8'h20, 3'd5, 1'b1, 1'b0);
    drive("tmo", 8'h60, 8'h20, 3'd5, 1'b1, 1'b0);
    drive("tmo", 8'h60, 8'h00, 3'd5, 1'b0, 1'b1);
    drive("tmo", 8'h60, 8'h40, 3'd6, 1'b1, 1'b0);
    drive("tmo", 8'h60, 8'h40, 3'd6, 1'b1, 1'b0);
    drive("tmo", 8'h00, 8'h00, 3'd6, 1'b0, 1'b0);
    // ptr = 7.

    // Wrap: after 7 releases, 0 beats 6; then 6 wins.
    drive("wrap", 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
    drive("wrap", 8'h00, 8'h00, 3'd7, 1'b0, 1'b0);
    drive("wrap", 8'h41, 8'h01, 3'd0, 1'b1, 1'b0);
    drive("wrap", 8'h40, 8'h00, 3'd0, 1'b0, 1'b0);
    drive("wrap", 8'h40, 8'h40, 3'd6, 1'b1, 1'b0);
    drive("wrap", 8'h00, 8'h00, 3'd6, 1'b0, 1'b0);
    // ptr = 7.

    // Drop exactly at the hold limit: normal release, no timeout.
    drive("edge", 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    drive("edge", 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    drive("edge", 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    drive("edge", 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    drive("edge", 8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
    // ptr = 2.

    // Reset asserted mid-grant clears outputs without a clock edge.
    drive("arst", 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("arst.pre_grant", arb_if.grant, 8'h10);
    rst_n = 1'b0;
    #1;
    check("arst.grant",       arb_if.grant,       8'h00);
    check("arst.grant_idx",   arb_if.grant_idx,   3'd0);
    check("arst.grant_valid", arb_if.grant_valid, 1'b0);
    check("arst.timeout",     arb_if.timeout,     1'b0);
    arb_if.req = 8'h00;
    #1;
    rst_n = 1'b1;

    // Pointer is back at 0 after reset.
    drive("post", 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
    drive("post", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
